hazard_ctrl: RTL

Hazard and forwarding controller for the five-stage MIPS pipeline; the producer of the `FlushE` and stall controls consumed by the D→E pipeline register and the fetch/decode registers. It forwards operands from M/W into D and E, and stalls on three conditions: load-use, branch/jr operand hazards, and syscall register drain. It also owns the multi-cycle divider busy tracker, which stalls `div` and `mfhi`/`mflo` in decode until the divider result is ready.

---
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Five-stage MIPS hazard/forwarding unit with multi-cycle divider
//            busy tracking. HAZARD_PERF_EN adds saturating stall counters.
// Revision : 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  RsE,
    input  logic [4:0]  RtE,
    input  logic [4:0]  WriteRegE,
    input  logic [4:0]  WriteRegM,
    input  logic [4:0]  WriteRegW,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MemtoRegE,
    input  logic        MemtoRegM,
    input  logic        BranchD,
    input  logic        JumpRegD,
    input  logic        divD,
    input  logic        divE,
    input  logic [1:0]  mfD,
    input  logic        sysD,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushE,
    output logic        ForwardAD,
    output logic        ForwardBD,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        DivBusy,
    output logic [31:0] StallCnt,
    output logic [31:0] DivStallCnt
);

    localparam logic [7:0] c_DIV_LAST = 8'(DIV_CYCLES - 1);
    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_BUSY     = 1'b1;

    logic [0:0] r_state;
    logic [7:0] r_cnt;

    logic w_m_wr, w_w_wr, w_e_wr;
    logic w_lwstall, w_brstall, w_sysstall, w_divstall, w_stall;
    logic w_e_hits_d, w_m_hits_d;

    // Register 0 is hard-wired, so a write to it never creates a dependency.
    assign w_e_wr = RegWriteE && (WriteRegE != 5'd0);
    assign w_m_wr = RegWriteM && (WriteRegM != 5'd0);
    assign w_w_wr = RegWriteW && (WriteRegW != 5'd0);

    always_comb begin
        ForwardAE = 2'b00;
        if (w_m_wr && (WriteRegM == RsE))      ForwardAE = 2'b10;
        else if (w_w_wr && (WriteRegW == RsE)) ForwardAE = 2'b01;
        ForwardBE = 2'b00;
        if (w_m_wr && (WriteRegM == RtE))      ForwardBE = 2'b10;
        else if (w_w_wr && (WriteRegW == RtE)) ForwardBE = 2'b01;
    end

    assign ForwardAD = w_m_wr && (WriteRegM == RsD);
    assign ForwardBD = w_m_wr && (WriteRegM == RtD);

    assign w_e_hits_d = (WriteRegE != 5'd0) && ((WriteRegE == RsD) || (WriteRegE == RtD));
    assign w_m_hits_d = (WriteRegM != 5'd0) && ((WriteRegM == RsD) || (WriteRegM == RtD));

    assign w_lwstall  = MemtoRegE && w_e_hits_d;
    assign w_brstall  = (BranchD || JumpRegD)
                      && ((RegWriteE && w_e_hits_d) || (MemtoRegM && w_m_hits_d));
    assign w_sysstall = sysD
                      && ((RegWriteE && ((WriteRegE == 5'd2) || (WriteRegE == 5'd4)))
                       || (RegWriteM && ((WriteRegM == 5'd2) || (WriteRegM == 5'd4)))
                       || (RegWriteW && ((WriteRegW == 5'd2) || (WriteRegW == 5'd4))));
    assign w_divstall = ((mfD != 2'b00) || divD) && (divE || DivBusy);
    assign w_stall    = w_lwstall | w_brstall | w_sysstall | w_divstall;

    assign StallF  = w_stall;
    assign StallD  = w_stall;
    assign FlushE  = w_stall | reset;
    assign DivBusy = (r_state == S_BUSY);

    // A divE arriving while BUSY cannot restart the count; it is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (divE) begin
                        r_state <= S_BUSY;
                        r_cnt   <= c_DIV_LAST;
                    end
                end
                S_BUSY: begin
                    if (r_cnt != 8'd0) r_cnt   <= r_cnt - 8'd1;
                    else               r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_div_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt     <= 32'd0;
            r_div_stall_cnt <= 32'd0;
        end else begin
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_divstall && (r_div_stall_cnt != 32'hFFFF_FFFF))
                r_div_stall_cnt <= r_div_stall_cnt + 32'd1;
        end
    end

    assign StallCnt    = r_stall_cnt;
    assign DivStallCnt = r_div_stall_cnt;
`else
    assign StallCnt    = 32'd0;
    assign DivStallCnt = 32'd0;
`endif

endmodule
`default_nettype wire
